// File: rtl/data_memory.sv
// Byte-addressable data memory for a single-cycle RISC-V core.
// Combinational loads, edge-committed stores, sticky access-error capture.
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] ReadData,
    input  logic        err_clr,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic [15:0] store_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [15:0] store_count_q, store_count_d;

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [4:0]    byte_sh;
    logic [4:0]    half_sh;
    logic          misalign;
    logic          ld_def;
    logic          st_def;
    logic          ld_fault;
    logic          st_fault;
    logic          fault;
    logic          st_commit;

    assign idx     = A[AW+1:2];
    assign word    = mem_q[idx];
    assign byte_sh = {A[1:0], 3'b000};
    assign half_sh = {A[1], 4'b0000};

    // Decode access legality from size code and address alignment.
    always_comb begin
        ld_def   = 1'b0;
        st_def   = 1'b0;
        misalign = 1'b0;
        unique case (funct3)
            F_B, F_BU: begin
                ld_def = 1'b1;
                st_def = (funct3 == F_B);
            end
            F_H, F_HU: begin
                ld_def   = 1'b1;
                st_def   = (funct3 == F_H);
                misalign = A[0];
            end
            F_W: begin
                ld_def   = 1'b1;
                st_def   = 1'b1;
                misalign = (A[1:0] != 2'b00);
            end
            default: begin
                ld_def = 1'b0;
                st_def = 1'b0;
            end
        endcase
        ld_fault  = MemRead & (~ld_def | misalign);
        st_fault  = MemWrite & (~st_def | misalign);
        fault     = ld_fault | st_fault;
        st_commit = MemWrite & ~st_fault;
    end

    // Select the load lane and extend it; faulting or idle loads read zero.
    always_comb begin
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        ReadData = 32'h0;
        sh_b     = word >> byte_sh;
        sh_h     = word >> half_sh;
        if (MemRead && !ld_fault) begin
            unique case (funct3)
                F_B:     ReadData = {{24{sh_b[7]}}, sh_b[7:0]};
                F_BU:    ReadData = {24'h0, sh_b[7:0]};
                F_H:     ReadData = {{16{sh_h[15]}}, sh_h[15:0]};
                F_HU:    ReadData = {16'h0, sh_h[15:0]};
                default: ReadData = word;
            endcase
        end
    end

    // Merge store data into only the addressed lanes.
    always_comb begin
        mem_d = mem_q;
        if (st_commit) begin
            unique case (funct3)
                F_B:     mem_d[idx][byte_sh +: 8]  = WD[7:0];
                F_H:     mem_d[idx][half_sh +: 16] = WD[15:0];
                default: mem_d[idx]                = WD;
            endcase
        end
    end

    // Sticky error capture; a fresh fault beats a same-cycle clear.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (fault && (!err_flag_q || err_clr)) begin
            err_flag_d = 1'b1;
            err_addr_d = A;
        end else if (!fault && err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    // Saturating count of committed stores.
    always_comb begin
        store_count_d = store_count_q;
        if (st_commit && store_count_q != 16'hFFFF) begin
            store_count_d = store_count_q + 16'd1;
        end
    end

    // State registers, all cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            err_flag_q    <= 1'b0;
            err_addr_q    <= 32'h0;
            store_count_q <= 16'h0;
        end else begin
            mem_q         <= mem_d;
            err_flag_q    <= err_flag_d;
            err_addr_q    <= err_addr_d;
            store_count_q <= store_count_d;
        end
    end

    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;
    assign store_count = store_count_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit words (power of two, at least 4).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 MemWrite  input  1  SHALL request a store this cycle.
REQ-005 MemRead  input  1  SHALL request a load this cycle.
REQ-006 funct3  input  3  SHALL select access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 A  input  32  SHALL carry the byte address, which is the datapath ALU result.
REQ-008 WD  input  32  SHALL carry store data, right-aligned.
REQ-009 ReadData  output  32  SHALL return load data, extended to 32 bits.
REQ-010 err_clr  input  1  SHALL be a synchronous clear of the error state.
REQ-011 err_flag  output  1  SHALL be a sticky access-error indicator.
REQ-012 err_addr  output  32  SHALL hold the address of the first faulting access.
REQ-013 store_count  output  16  SHALL count committed stores.

Function
REQ-014 Word index SHALL be A[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes.
REQ-015 ReadData SHALL be combinational from A, funct3, MemRead and current array contents, giving zero-latency use by a single-cycle core.
REQ-016 Load byte SHALL select lane A[1:0]; load half SHALL select lane A[1]; 000 and 001 SHALL sign-extend; 100 and 101 SHALL zero-extend; 010 SHALL pass the word unchanged.
REQ-017 ReadData SHALL be 0 when MemRead=0, or when the load is faulting.
REQ-018 A store SHALL update only the addressed lanes on the rising clk edge.
REQ-019 Store lane mapping: SB writes WD[7:0] to lane A[1:0]; SH writes WD[15:0] to lane A[1]; SW writes all 4 lanes. Other lanes SHALL be unchanged.
REQ-020 An access is faulting when funct3 is not one of the defined codes, when a half access has A[0]=1, or when a word access has A[1:0]!=0.
REQ-021 For stores, only codes 000, 001 and 010 are defined; 100 and 101 SHALL be faulting.
REQ-022 A faulting store SHALL be suppressed, leaving no array change and no count change.
REQ-023 When MemRead=1 and MemWrite=1 together, the store SHALL commit at the edge, and ReadData in that cycle SHALL reflect the pre-edge contents.
REQ-024 A fault occurs when MemRead or MemWrite is 1 and the access is faulting. On a fault with err_flag=0, the edge SHALL set err_flag=1 and load A into err_addr.
REQ-025 While err_flag=1, further faults SHALL leave err_addr unchanged.
REQ-026 err_clr=1 SHALL clear err_flag at the edge; err_addr SHALL keep its value.
REQ-027 If err_clr=1 and a fault occur in the same cycle, the fault SHALL win: err_flag=1 and err_addr=A.
REQ-028 store_count SHALL increment by 1 per committed store and saturate at 16'hFFFF.
REQ-029 With MemRead=0 and MemWrite=0, there SHALL be no state change other than the err_clr effect.

Reset
REQ-030 rst=0 SHALL immediately clear all DEPTH words to 0, err_flag to 0, err_addr to 0 and store_count to 0, regardless of clk.
REQ-031 Reset asserted mid-store SHALL discard that store; the first edge after rst rises SHALL operate normally.
REQ-032 After reset, any defined load SHALL return 0.

Verification
REQ-033 Test 1: SW 0x8000_00FF to A=0x10, then LB / LBU / LH / LHU / LW at A=0x10 -> 0xFFFF_FFFF / 0x0000_00FF / 0x0000_00FF / 0x0000_00FF / 0x8000_00FF; LH at A=0x12 -> 0xFFFF_8000.
REQ-034 Test 2: SW 0 to A=0x20, then SB 0xAB to A=0x21 and SH 0x1234 to A=0x22 -> LW at 0x20 reads 0x1234_AB00; store_count=3.
REQ-035 Test 3: SW to A=0x22, then SH to A=0x23 -> both suppressed; err_flag=1, err_addr=0x22; LW at 0x20 returns the prior value; store_count unchanged.
REQ-036 Test 4: err_clr=1 together with LW at A=0x41 -> err_flag stays 1 and err_addr=0x41; next cycle err_clr alone -> err_flag=0 and err_addr still 0x41.
REQ-037 Test 5: DEPTH=256, SW 0xDEAD_BEEF to A=0x400 -> LW at A=0x0 returns 0xDEAD_BEEF (aliasing); pulse rst low between edges -> LW at A=0x0 returns 0, all outputs 0.
REQ-038 Test 6: MemRead=1 and MemWrite=1 with SW 0x5 to A=0x8 when word 2=0x3 -> ReadData=0x3 that cycle, then 0x5 after the edge.
